// File: rtl/random_engine_dpath.sv
// ---------------------------------------------------------------------------
// random_engine_dpath
//   Galois LFSR that advances once for each accepted step request. Every new
//   LFSR state is queued in a small FIFO, and a val/rdy stream drains it.
//   While the FIFO is full, stall is raised and step requests are dropped.
//   The controller is expected to hold lfsr_en until the step is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   lfsr_en    step request from the controller
//   seed_load  load seed (zero maps to SEED) and flush the FIFO
//   seed       seed value, sampled when seed_load=1
//   stall      FIFO full; the step request this cycle is ignored
//   out_val    FIFO non-empty
//   out_rdy    consumer ready
//   out_data   FIFO head entry; 0 when empty
//   count      current FIFO occupancy
// ---------------------------------------------------------------------------
module random_engine_dpath #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
   parameter int               DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       lfsr_en,
   input  logic                       seed_load,
   input  logic [WIDTH-1:0]           seed,
   output logic                       stall,
   output logic                       out_val,
   input  logic                       out_rdy,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic [WIDTH-1:0] w_lfsr_nxt;
   logic             w_full;
   logic             w_empty;
   logic             w_step;
   logic             w_pop;

   // Galois step: shift right and fold TAPS in when the bit that falls out is 1.
   // A nonzero state never maps to zero, so lockup cannot happen.
   assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);

   // full and empty depend only on registered count. This keeps out_rdy from
   // having any combinational path to stall.
   assign w_full  = (r_count == FULL);
   assign w_empty = (r_count == '0);

   // seed_load overrides both sides of the FIFO for this cycle.
   assign w_step = lfsr_en & ~w_full & ~seed_load;
   assign w_pop  = ~w_empty & out_rdy & ~seed_load;

   // LFSR state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lfsr <= SEED;
      end else if (seed_load) begin
         r_lfsr <= (seed == '0) ? SEED : seed;
      end else if (w_step) begin
         r_lfsr <= w_lfsr_nxt;
      end
   end

   // FIFO storage. The entry written is the new LFSR state, not the old one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_step) begin
         r_mem[r_wptr] <= w_lfsr_nxt;
      end
   end

   // Pointers wrap by natural overflow because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (seed_load) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_step) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         // A push and a pop in the same cycle leave occupancy unchanged.
         case ({w_step, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign stall    = w_full;
   assign out_val  = ~w_empty;
   assign out_data = w_empty ? '0 : r_mem[r_rptr];
   assign count    = r_count;

endmodule

// File: tb/tb_random_engine_dpath.sv
// ---------------------------------------------------------------------------
// tb_random_engine_dpath
//   Directed scenarios plus a randomized run. All outputs are compared with a
//   queue-based reference model of the LFSR stream.
// ---------------------------------------------------------------------------
module tb_random_engine_dpath;

   localparam int          W    = 16;
   localparam int          D    = 4;
   localparam int          CW   = $clog2(D+1);
   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk;
   logic          rst;
   logic          lfsr_en;
   logic          seed_load;
   logic [W-1:0]  seed;
   logic          stall;
   logic          out_val;
   logic          out_rdy;
   logic [W-1:0]  out_data;
   logic [CW-1:0] count;

   random_engine_dpath #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .lfsr_en   (lfsr_en),
      .seed_load (seed_load),
      .seed      (seed),
      .stall     (stall),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_data  (out_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: the current generator value and the queue of values
   // that have been generated but not yet consumed.
   logic [15:0] m_lfsr;
   logic [15:0] m_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? TAPS : 16'h0000);
   endfunction

   task automatic check_outs(input string tag);
      int n;
      n = m_q.size();
      chk({tag, "_count"}, 32'(count), 32'(n));
      chk({tag, "_val"},   32'(out_val), 32'(n != 0));
      chk({tag, "_stall"}, 32'(stall), 32'(n == D));
      chk({tag, "_data"},  32'(out_data), (n != 0) ? 32'(m_q[0]) : 32'h0);
   endtask

   // Called just after a negedge. Drives the inputs, advances one posedge,
   // updates the model, then checks outputs on the following negedge.
   task automatic cyc(input logic en, input logic ld, input logic [15:0] sd,
                      input logic rdy, input string tag);
      bit full;
      lfsr_en   = en;
      seed_load = ld;
      seed      = sd;
      out_rdy   = rdy;
      @(posedge clk);
      full = (m_q.size() == D);
      if (ld) begin
         m_lfsr = (sd == 16'h0) ? SEED : sd;
         m_q.delete();
      end else begin
         if (rdy && m_q.size() != 0) void'(m_q.pop_front());
         if (en && !full) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_q.push_back(m_lfsr);
         end
      end
      @(negedge clk);
      check_outs(tag);
   endtask

   logic [15:0] exp4 [4];

   initial begin
      exp4[0] = 16'hE270; exp4[1] = 16'h7138; exp4[2] = 16'h389C; exp4[3] = 16'h1C4E;
      rst = 1'b0; lfsr_en = 1'b0; seed_load = 1'b0; seed = '0; out_rdy = 1'b0;
      m_lfsr = SEED;
      m_q.delete();
      @(negedge clk);
      @(negedge clk);
      check_outs("reset");
      rst = 1'b1;

      // 1: fill the FIFO. The fifth request must be dropped.
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 16'h0, 1'b0, "t1");
         if (i == 3) begin
            chk("t1_stall4", 32'(stall), 32'd1);
            chk("t1_count4", 32'(count), 32'd4);
         end
      end

      // 2: drain the FIFO and confirm push order against known values.
      for (int i = 0; i < 4; i++) begin
         chk("t2_data", 32'(out_data), 32'(exp4[i]));
         cyc(1'b0, 1'b0, 16'h0, 1'b1, "t2");
         if (i == 0) chk("t2_stall_drop", 32'(stall), 32'd0);
      end
      chk("t2_empty_val", 32'(out_val), 32'd0);
      chk("t2_empty_data", 32'(out_data), 32'd0);

      // The dropped request must not have advanced the LFSR past 1C4E.
      cyc(1'b1, 1'b0, 16'h0, 1'b0, "t1b");
      chk("t1_nostep", 32'(out_data), 32'h0E27);

      // 3: at count 2, push and pop together while the pointers wrap.
      cyc(1'b1, 1'b0, 16'h0, 1'b0, "t3pre");
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 16'h0, 1'b1, "t3");
         chk("t3_count", 32'(count), 32'd2);
      end

      // 4: at count 3, a zero-seed load flushes the FIFO and blocks the push.
      cyc(1'b1, 1'b0, 16'h0, 1'b0, "t4pre");
      chk("t4_pre_count", 32'(count), 32'd3);
      cyc(1'b1, 1'b1, 16'h0, 1'b1, "t4");
      chk("t4_count", 32'(count), 32'd0);
      chk("t4_val", 32'(out_val), 32'd0);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, "t4b");
      chk("t4_first", 32'(out_data), 32'hE270);

      // 5: seed 0001 produces B400, then 5A00.
      cyc(1'b0, 1'b1, 16'h0001, 1'b0, "t5ld");
      cyc(1'b1, 1'b0, 16'h0, 1'b0, "t5a");
      cyc(1'b1, 1'b0, 16'h0, 1'b0, "t5b");
      chk("t5_d0", 32'(out_data), 32'hB400);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, "t5c");
      chk("t5_d1", 32'(out_data), 32'h5A00);

      // Randomized traffic, with occasional reseeds that include seed=0.
      for (int i = 0; i < 400; i++) begin
         logic        en, ld, rdy;
         logic [15:0] sd;
         en  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) == 0);
         ld  = ($urandom_range(0, 24) == 0);
         sd  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         cyc(en, ld, sd, rdy, "rnd");
      end

      // 6: asynchronous reset between clock edges, with count=3.
      cyc(1'b0, 1'b1, 16'h1234, 1'b0, "t6ld");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0, "t6fill");
      chk("t6_pre_count", 32'(count), 32'd3);
      lfsr_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("t6_val", 32'(out_val), 32'd0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_data", 32'(out_data), 32'd0);
      chk("t6_stall", 32'(stall), 32'd0);
      m_lfsr = SEED;
      m_q.delete();
      #1;
      rst = 1'b1;
      cyc(1'b1, 1'b0, 16'h0, 1'b0, "t6b");
      chk("t6_first", 32'(out_data), 32'hE270);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
